// File: rtl/tag_read_stage_mc.sv
// tag_read_stage_mc
//   Splits one motion-compensation reference block into the cache lines it
//   touches and emits one line descriptor per accepted output beat, in raster
//   order (x inner, y outer).
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   flush                abort any walk in progress, blocks new acceptance
//   req_*                block request (plane, ref index, start x/y, w-1, h-1,
//                        destination offset); accepted on req_valid && req_ready
//   out_valid/out_ready  descriptor handshake; out_last marks the final line
//   out_plane/out_ref_idx echo of the request
//   tag_addr, set_addr   cache tag and set index of the current line
//   cl_sx, cl_sy         start position inside the cache line
//   dst_sx..dst_ey       destination rectangle covered by this line
module tag_read_stage_mc #(
    parameter int unsigned X_ADDR_WDTH   = 12,
    parameter int unsigned Y_ADDR_WDTH   = 12,
    parameter int unsigned REF_ADDR_WDTH = 4,
    parameter int unsigned DIM_WDTH      = 4,
    parameter int unsigned CLW_L         = 3,
    parameter int unsigned CLH_L         = 3,
    parameter int unsigned CLW_C         = 2,
    parameter int unsigned CLH_C         = 2,
    parameter int unsigned SET_X_BITS    = 2,
    parameter int unsigned SET_Y_BITS    = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           flush,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_plane,
    input  logic [REF_ADDR_WDTH-1:0]                       req_ref_idx,
    input  logic [X_ADDR_WDTH-1:0]                         req_sx,
    input  logic [Y_ADDR_WDTH-1:0]                         req_sy,
    input  logic [DIM_WDTH-1:0]                            req_w,
    input  logic [DIM_WDTH-1:0]                            req_h,
    input  logic [DIM_WDTH-1:0]                            req_dx,
    input  logic [DIM_WDTH-1:0]                            req_dy,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic                                           out_last,
    output logic                                           out_plane,
    output logic [REF_ADDR_WDTH-1:0]                       out_ref_idx,
    output logic [REF_ADDR_WDTH+X_ADDR_WDTH+Y_ADDR_WDTH-1:0] tag_addr,
    output logic [SET_X_BITS+SET_Y_BITS-1:0]               set_addr,
    output logic [CLW_L-1:0]                               cl_sx,
    output logic [CLH_L-1:0]                               cl_sy,
    output logic [DIM_WDTH-1:0]                            dst_sx,
    output logic [DIM_WDTH-1:0]                            dst_ex,
    output logic [DIM_WDTH-1:0]                            dst_sy,
    output logic [DIM_WDTH-1:0]                            dst_ey
);

    localparam int unsigned TAG_W = REF_ADDR_WDTH + X_ADDR_WDTH + Y_ADDR_WDTH;
    localparam int unsigned CL_MAX = (CLW_L > CLH_L) ? CLW_L : CLH_L;
    localparam int unsigned CC_MAX = (CLW_C > CLH_C) ? CLW_C : CLH_C;
    // Wide enough that dst + line size - 1 and d + w never overflow.
    localparam int unsigned EW = DIM_WDTH + ((CL_MAX > CC_MAX) ? CL_MAX : CC_MAX) + 2;
    localparam logic [X_ADDR_WDTH-1:0] ONES_X = '1;
    localparam logic [Y_ADDR_WDTH-1:0] ONES_Y = '1;

    typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic                       plane_q;
    logic [REF_ADDR_WDTH-1:0]   ref_q;
    logic [X_ADDR_WDTH-1:0]     sx_q;
    logic [Y_ADDR_WDTH-1:0]     sy_q;
    logic [DIM_WDTH-1:0]        w_q, h_q, dx_q, dy_q;
    logic [X_ADDR_WDTH-1:0]     lx_q, lx_d;
    logic [Y_ADDR_WDTH-1:0]     ly_q, ly_d;
    logic [DIM_WDTH-1:0]        dst_sx_q, dst_sx_d, dst_sy_q, dst_sy_d;

    int unsigned                xs, ys, acc_xs, acc_ys;
    logic [X_ADDR_WDTH-1:0]     lx0, lx1, lx_mask;
    logic [Y_ADDR_WDTH-1:0]     ly0, ly1, ly_mask;
    logic                       first_col, first_row, last_line, accept;
    logic [EW-1:0]              cw_m1, ch_m1, ex_cand, ex_lim, ey_cand, ey_lim;

    // Line geometry of the latched request.
    always_comb begin
        xs        = plane_q ? CLW_C : CLW_L;
        ys        = plane_q ? CLH_C : CLH_L;
        lx0       = sx_q >> xs;
        lx1       = (sx_q + X_ADDR_WDTH'(w_q)) >> xs;
        ly0       = sy_q >> ys;
        ly1       = (sy_q + Y_ADDR_WDTH'(h_q)) >> ys;
        // Line coordinates wrap within the line-address range, not the sample range.
        lx_mask   = ONES_X >> xs;
        ly_mask   = ONES_Y >> ys;
        first_col = (lx_q == lx0);
        first_row = (ly_q == ly0);
        last_line = (lx_q == lx1) && (ly_q == ly1);
        cw_m1     = plane_q ? EW'((1 << CLW_C) - 1) : EW'((1 << CLW_L) - 1);
        ch_m1     = plane_q ? EW'((1 << CLH_C) - 1) : EW'((1 << CLH_L) - 1);

        cl_sx     = first_col ? CLW_L'(sx_q & ~(ONES_X << xs)) : '0;
        cl_sy     = first_row ? CLH_L'(sy_q & ~(ONES_Y << ys)) : '0;

        ex_cand   = EW'(dst_sx_q) + cw_m1 - EW'(cl_sx);
        ex_lim    = EW'(dx_q) + EW'(w_q);
        ey_cand   = EW'(dst_sy_q) + ch_m1 - EW'(cl_sy);
        ey_lim    = EW'(dy_q) + EW'(h_q);
        dst_ex    = (ex_cand < ex_lim) ? DIM_WDTH'(ex_cand) : DIM_WDTH'(ex_lim);
        dst_ey    = (ey_cand < ey_lim) ? DIM_WDTH'(ey_cand) : DIM_WDTH'(ey_lim);
        dst_sx    = dst_sx_q;
        dst_sy    = dst_sy_q;
    end

    assign accept = (state_q == IDLE) && req_valid && !flush;

    always_comb begin
        state_d  = state_q;
        lx_d     = lx_q;
        ly_d     = ly_q;
        dst_sx_d = dst_sx_q;
        dst_sy_d = dst_sy_q;
        acc_xs   = req_plane ? CLW_C : CLW_L;
        acc_ys   = req_plane ? CLH_C : CLH_L;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = WALK;
                    lx_d     = req_sx >> acc_xs;
                    ly_d     = req_sy >> acc_ys;
                    dst_sx_d = req_dx;
                    dst_sy_d = req_dy;
                end
            end
            WALK: begin
                if (out_ready) begin
                    if (last_line) begin
                        state_d = DRAIN;
                    end else if (lx_q == lx1) begin
                        lx_d     = lx0;
                        ly_d     = (ly_q + Y_ADDR_WDTH'(1)) & ly_mask;
                        dst_sx_d = dx_q;
                        dst_sy_d = dst_ey + DIM_WDTH'(1);
                    end else begin
                        lx_d     = (lx_q + X_ADDR_WDTH'(1)) & lx_mask;
                        dst_sx_d = dst_ex + DIM_WDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            plane_q  <= 1'b0;
            ref_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            lx_q     <= '0;
            ly_q     <= '0;
            dst_sx_q <= '0;
            dst_sy_q <= '0;
        end else begin
            state_q  <= state_d;
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            dst_sx_q <= dst_sx_d;
            dst_sy_q <= dst_sy_d;
            if (accept) begin
                plane_q <= req_plane;
                ref_q   <= req_ref_idx;
                sx_q    <= req_sx;
                sy_q    <= req_sy;
                w_q     <= req_w;
                h_q     <= req_h;
                dx_q    <= req_dx;
                dy_q    <= req_dy;
            end
        end
    end

    assign req_ready   = (state_q == IDLE) && !flush;
    assign out_valid   = (state_q == WALK);
    // Gated so the all-zero reset geometry does not read as a last line.
    assign out_last    = (state_q == WALK) && last_line;
    assign out_plane   = plane_q;
    assign out_ref_idx = ref_q;
    assign tag_addr    = TAG_W'({ref_q, ly_q[Y_ADDR_WDTH-1:SET_Y_BITS], lx_q[X_ADDR_WDTH-1:SET_X_BITS]});
    assign set_addr    = {ly_q[SET_Y_BITS-1:0], lx_q[SET_X_BITS-1:0]};

endmodule
